// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester
// count, port indices and the address legality check.
package dmem_pkg;

   localparam int NUM_REQ  = 2;
   localparam int PORT_LSU = 0;
   localparam int PORT_DMA = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // A request is illegal when misaligned or when its word index falls
   // outside the attached memory.
   function automatic logic addr_illegal(input logic [31:0] a, input int unsigned depth);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
   endfunction

   // One-hot vector for a requester index (bit 0 = LSU, bit 1 = DMA).
   function automatic logic [NUM_REQ-1:0] port_onehot(input logic idx);
      return {idx, ~idx};
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Arbitration decision for the two data-memory requesters.
// Build option DMEM_ARB_RR_EN: round-robin between the ports; otherwise
// fixed priority with the core LSU (port 0) always winning.
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               take,
   output logic               pick
);

`ifdef DMEM_ARB_RR_EN
   logic ptr;

   // On a tie the preferred port wins, otherwise whichever port is asking.
   always_comb begin
      pick = 1'b0;
      if (req[PORT_LSU] && req[PORT_DMA]) begin
         pick = ptr;
      end else if (req[PORT_DMA]) begin
         pick = 1'b1;
      end
   end

   // After every accepted grant the other port becomes the preferred one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (take) begin
         ptr <= ~pick;
      end
   end
`else
   logic unused_pick_inputs;
   assign unused_pick_inputs = ^{clk, rst_n, take};

   // Port 1 only wins when port 0 is not asking.
   always_comb begin
      pick = !req[PORT_LSU] && req[PORT_DMA];
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access
// every three cycles, fixed latency (gnt at T+1, rvalid at T+2).
// Build option DMEM_ARB_RR_EN selects round-robin arbitration in
// dmem_rr_pick; the default build uses fixed priority (port 0 first).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ-1:0][31:0]  addr,
   input  logic [NUM_REQ-1:0][31:0]  wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [31:0]               rdata,
   output logic                      err,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic [31:0]               mem_rdata
);

   arb_state_t state;
   logic       owner;
   logic       we_q;
   logic       bad_q;
   logic       take;
   logic       pick;
   logic       sel_bad;

   assign take    = (state == IDLE) && (|req);
   assign sel_bad = addr_illegal(addr[pick], DEPTH);

   dmem_rr_pick u_pick (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .take  (take),
      .pick  (pick)
   );

   // Access sequencer: latch the winner, strobe memory for one cycle,
   // then present the response for one cycle; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         we_q      <= 1'b0;
         bad_q     <= 1'b0;
         gnt       <= '0;
         rvalid    <= '0;
         rdata     <= '0;
         err       <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state     <= ACCESS;
                  owner     <= pick;
                  we_q      <= we[pick];
                  bad_q     <= sel_bad;
                  gnt       <= port_onehot(pick);
                  mem_addr  <= {2'b00, addr[pick][31:2]};
                  mem_wdata <= wdata[pick];
                  mem_read  <= !sel_bad && !we[pick];
                  mem_write <= !sel_bad && we[pick];
               end
            end
            ACCESS: begin
               state     <= RESP;
               gnt       <= '0;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               rvalid    <= port_onehot(owner);
               err       <= bad_q;
               rdata     <= (!bad_q && !we_q) ? mem_rdata : 32'h0;
            end
            RESP: begin
               state  <= IDLE;
               rvalid <= '0;
               err    <= 1'b0;
               rdata  <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory
// and a scoreboard of expected responses.
module tb_dmem_arbiter;

   localparam int DEPTH = 1024;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req;
   logic [1:0]        we;
   logic [1:0][31:0]  addr;
   logic [1:0][31:0]  wdata;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [31:0]       rdata;
   logic              err;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0]       mem     [DEPTH];
   logic [31:0]       ref_mem [DEPTH];
   logic              mem_init;
   int                wr_count = 0;

   int test_count = 0;
   int fail_count = 0;

   typedef struct {
      int          port;
      logic        wr;
      logic        legal;
      logic        err;
      logic [31:0] word;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sbq[$];

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .err       (err),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural data memory: combinational read, write on the clock edge.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
      end else if (mem_write && (mem_addr < 32'(DEPTH))) begin
         mem[mem_addr[9:0]] <= mem_wdata;
      end
   end

   assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[9:0]] : 32'hBAD0_BAD0;

   // Count real write edges seen by the memory.
   always @(posedge clk) begin
      if (mem_write) wr_count <= wr_count + 1;
   end

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Build the expected response for one access and update the reference memory.
   task automatic pushExpect(input int port, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.port  = port;
      e.wr    = w;
      e.wdata = d;
      e.word  = {2'b00, a[31:2]};
      e.legal = (a[1:0] == 2'b00) && (e.word < 32'(DEPTH));
      e.err   = !e.legal;
      e.rdata = (e.legal && !w) ? ref_mem[e.word[9:0]] : 32'h0;
      if (e.legal && w) ref_mem[e.word[9:0]] = d;
      sbq.push_back(e);
   endtask

   // Raise one requester and record what it should get back.
   task automatic applyStimulus(input int port, input logic w, input logic [31:0] a, input logic [31:0] d);
      pushExpect(port, w, a, d);
      req[port]   = 1'b1;
      we[port]    = w;
      addr[port]  = a;
      wdata[port] = d;
   endtask

   // Walk one access through ACCESS, RESP and back to IDLE, checking each cycle.
   task automatic runAccess(input bit drop);
      exp_t e;
      e = sbq[0];
      @(negedge clk);
      if (drop) req = 2'b00;
      checkOutput("gnt", 32'(gnt), 32'(1) << e.port);
      checkOutput("access_rvalid", 32'(rvalid), 32'h0);
      checkOutput("mem_read", 32'(mem_read), 32'(e.legal && !e.wr));
      checkOutput("mem_write", 32'(mem_write), 32'(e.legal && e.wr));
      if (e.legal) checkOutput("mem_addr", mem_addr, e.word);
      if (e.legal && e.wr) checkOutput("mem_wdata", mem_wdata, e.wdata);
      @(negedge clk);
      e = sbq.pop_front();
      checkOutput("rvalid", 32'(rvalid), 32'(1) << e.port);
      checkOutput("err", 32'(err), 32'(e.err));
      checkOutput("rdata", rdata, e.rdata);
      checkOutput("resp_gnt", 32'(gnt), 32'h0);
      checkOutput("resp_strobe", 32'({mem_read, mem_write}), 32'h0);
      @(negedge clk);
      checkOutput("idle_rvalid", 32'(rvalid), 32'h0);
      checkOutput("idle_err", 32'(err), 32'h0);
      checkOutput("idle_rdata", rdata, 32'h0);
      checkOutput("idle_gnt", 32'(gnt), 32'h0);
   endtask

   int wr_before;

   initial begin
      rst_n    = 1'b0;
      req      = 2'b00;
      we       = 2'b00;
      addr     = '0;
      wdata    = '0;
      mem_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
      repeat (3) @(negedge clk);

      checkOutput("rst_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
      checkOutput("rst_strobe", 32'({mem_read, mem_write}), 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      mem_init = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);

      // Single load, with the request dropped after one cycle.
      applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0);
      runAccess(1'b1);

      // Store then load on port 1.
      wr_before = wr_count;
      applyStimulus(1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
      runAccess(1'b1);
      checkOutput("store_once", 32'(wr_count - wr_before), 32'h1);
      checkOutput("store_mem", mem[8], 32'hDEAD_BEEF);
      applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0);
      runAccess(1'b1);

      // Both ports held high for four accesses.
      req   = 2'b11;
      we    = 2'b00;
      addr[0] = 32'h0000_0040;
      addr[1] = 32'h0000_0044;
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         pushExpect(k % 2, 1'b0, (k % 2 == 0) ? 32'h0000_0040 : 32'h0000_0044, 32'h0);
`else
         pushExpect(0, 1'b0, 32'h0000_0040, 32'h0);
`endif
      end
      for (int k = 0; k < 4; k++) begin
         runAccess(1'b0);
      end
      req = 2'b00;

      // Illegal requests: misaligned, out of range, and a misaligned store.
      applyStimulus(0, 1'b0, 32'h0000_0002, 32'h0);
      runAccess(1'b1);
      applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0);
      runAccess(1'b1);
      wr_before = wr_count;
      applyStimulus(1, 1'b1, 32'h0000_0FFE, 32'h5555_AAAA);
      runAccess(1'b1);
      checkOutput("illegal_nowrite", 32'(wr_count - wr_before), 32'h0);

      // Highest legal word.
      applyStimulus(1, 1'b0, 32'h0000_0FFC, 32'h0);
      runAccess(1'b1);

      // A handful of random legal accesses from either port.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       32'($urandom_range(0, DEPTH - 1)) << 2, $urandom);
         runAccess(1'b1);
      end

      // Reset in the middle of a store from port 0.
      req      = 2'b01;
      we       = 2'b01;
      addr[0]  = 32'h0000_0030;
      wdata[0] = 32'h1234_5678;
      @(negedge clk);
      req = 2'b00;
      checkOutput("mid_gnt_before", 32'(gnt), 32'h1);
      wr_before = wr_count;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_gnt", 32'(gnt), 32'h0);
      checkOutput("mid_strobe", 32'({mem_read, mem_write}), 32'h0);
      checkOutput("mid_mem_addr", mem_addr, 32'h0);
      checkOutput("mid_mem_wdata", mem_wdata, 32'h0);
      checkOutput("mid_rvalid", 32'(rvalid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mid_nowrite", 32'(wr_count - wr_before), 32'h0);
      checkOutput("mid_mem", mem[12], ref_mem[12]);
      checkOutput("mid_rvalid_after", 32'(rvalid), 32'h0);

      // After reset port 0 is preferred again.
      we      = 2'b00;
      addr[1] = 32'h0000_0054;
      applyStimulus(0, 1'b0, 32'h0000_0050, 32'h0);
      req[1] = 1'b1;
      runAccess(1'b1);

      @(negedge clk);
      checkOutput("end_gnt", 32'(gnt), 32'h0);
      checkOutput("sb_empty", 32'(sbq.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words in the attached data_mem.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  per-requester access request; bit 0 = core LSU, bit 1 = DMA/debug.
REQ-005 SHALL have port we  input  2  per-requester write enable (1 = store, 0 = load).
REQ-006 SHALL have port addr  input  2x32  per-requester byte address.
REQ-007 SHALL have port wdata  input  2x32  per-requester store data.
REQ-008 SHALL have port gnt  output  2  one-hot grant pulse.
REQ-009 SHALL have port rvalid  output  2  one-hot response pulse.
REQ-010 SHALL have port rdata  output  32  load data, shared by both requesters.
REQ-011 SHALL have port err  output  1  response error flag, qualified by rvalid.
REQ-012 SHALL have ports mem_read, mem_write  output  1 each; mem_addr, mem_wdata  output  32 each; mem_rdata  input  32; these drive data_mem (combinational read, write on clk edge).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req bit is high at a clk edge; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 SHALL latch owner, we, addr and wdata of the winning requester on the IDLE->ACCESS edge; later changes to req or its fields SHALL NOT affect the access in flight.
REQ-015 SHALL assert gnt[owner] for exactly the ACCESS cycle, all other cycles 0.
REQ-016 SHALL in ACCESS drive mem_addr = {2'b00, addr[31:2]}, mem_wdata = latched wdata, mem_read = !we, mem_write = we, gated off when the request is illegal.
REQ-017 SHALL flag a request illegal when addr[1:0] != 0 or addr[31:2] >= DEPTH; illegal requests SHALL cause no memory strobe and respond with err = 1, rdata = 0.
REQ-018 SHALL register mem_rdata at the end of ACCESS for a legal load and present it on rdata during RESP; rdata = 0 for stores.
REQ-019 SHALL assert rvalid[owner] and err for exactly the RESP cycle; err = 0, rdata = 0 outside RESP.
REQ-020 SHALL give fixed latency: req sampled at edge T, gnt in cycle T+1, rvalid in cycle T+2; peak throughput one access per 3 cycles.
REQ-021 SHALL ignore requests while in ACCESS or RESP; a pending req held high SHALL be arbitrated on the next IDLE edge.
REQ-022 SHALL keep mem_read = mem_write = 0 in IDLE and RESP.

Reset
REQ-023 SHALL on rst_n low immediately force state IDLE, gnt = 0, rvalid = 0, rdata = 0, err = 0, mem_read = mem_write = 0, mem_addr = mem_wdata = 0, round-robin pointer = 0 (port 0 preferred next).
REQ-024 SHALL abandon an in-flight access on reset mid-operation without issuing gnt or rvalid for it.

Configuration
REQ-025 SHALL, with DMEM_ARB_RR_EN defined, arbitrate round-robin: on simultaneous req, grant the port not granted last; pointer updates on each grant.
REQ-026 SHALL, without DMEM_ARB_RR_EN, use fixed priority: port 0 always wins over port 1; no pointer state.

Structure
REQ-027 SHALL take the state enum (IDLE/ACCESS/RESP), NUM_REQ = 2 and the port-index constants from shared package dmem_pkg.
REQ-028 SHALL place the arbitration decision (RR or fixed) in sub-module dmem_rr_pick; the FSM and datapath stay in dmem_arbiter.

Verification
REQ-029 Single load: port 0 load addr 0x0000_0010 with mem word 4 = 0x4 -> gnt[0] at T+1, mem_read=1, mem_addr=4, rvalid[0] at T+2, rdata=0x4, err=0.
REQ-030 Store then load: port 1 store 0x0000_0020 = 0xDEAD_BEEF, then load same -> mem_write=1 at mem_addr=8 once; load returns 0xDEAD_BEEF.
REQ-031 Contention: req=2'b11 held 4 accesses -> RR build grants 0,1,0,1; fixed build grants 0,0,0,0.
REQ-032 Illegal: load addr 0x0000_0002 and addr 0x0000_1000 (DEPTH 1024) -> no mem strobe, rvalid with err=1, rdata=0.
REQ-033 Reset mid-op: rst_n low during ACCESS of a store -> no mem_write edge, all outputs 0, next request served from IDLE with port 0 preferred.
REQ-034 Request drop: req[0] high one cycle only then low -> access still completes, rvalid[0] two cycles later.
